// File: rtl/regfile_sb.sv
// Integer register file with NREAD combinational read ports, one write-back port and a busy-bit scoreboard.
// Optional same-cycle write-back bypass on the read ports: define REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NREAD = 2,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_ready,
    input  logic                  alloc_valid,
    input  logic [AW-1:0]         alloc_addr,
    output logic                  alloc_ok,
    input  logic                  wb_valid,
    input  logic [AW-1:0]         wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush,
    output logic [CW-1:0]         busy_count,
    output logic                  wb_err
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [CW-1:0]    busy_count_nxt;
    logic             wb_live;

    assign wb_live = wb_valid && (wb_addr != '0);

    // A same-cycle write-back to the requested register frees it, so a new allocation may proceed
    assign alloc_ok = reset && alloc_valid && !flush &&
                      ((alloc_addr == '0) || !busy[alloc_addr] ||
                       (wb_valid && (wb_addr == alloc_addr)));

    // Allocation is applied after the write-back clear, so it wins on a shared address
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (wb_live)
                busy_nxt[wb_addr] = 1'b0;
            if (alloc_ok && (alloc_addr != '0))
                busy_nxt[alloc_addr] = 1'b1;
        end
    end

    always_comb begin
        busy_count_nxt = '0;
        for (int unsigned i = 0; i < NREGS; i++)
            busy_count_nxt = busy_count_nxt + CW'(busy_nxt[i]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++)
                regs[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
            wb_err     <= 1'b0;
        end else begin
            if (wb_live) begin
                regs[wb_addr] <= wb_data;
                if (!busy[wb_addr])
                    wb_err <= 1'b1;
            end
            busy       <= busy_nxt;
            busy_count <= busy_count_nxt;
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
        ra       = '0;
        rd_data  = '0;
        rd_ready = '0;
        for (int unsigned k = 0; k < NREAD; k++) begin
            ra = rd_addr[k*AW +: AW];
            if (ra == '0) begin
                rd_data[k*XLEN +: XLEN] = '0;
                rd_ready[k]             = 1'b1;
`ifdef REGFILE_BYPASS_EN
            end else if (wb_live && (wb_addr == ra)) begin
                rd_data[k*XLEN +: XLEN] = wb_data;
                rd_ready[k]             = 1'b1;
`endif
            end else begin
                rd_data[k*XLEN +: XLEN] = regs[ra];
                rd_ready[k]             = !busy[ra];
            end
        end
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file with NREAD combinational read ports, one synchronous write-back port, and a per-register scoreboard of pending-write busy bits. Decode allocates a destination; write-back fills it and clears its busy bit. Read ports report both data and a ready flag, so the issue stage can stall on RAW hazards. Sits between decode/issue and the write-back stage of the core pipeline.

Parameters:
XLEN, 32, data width in bits.
NREGS, 32, number of architectural registers; power of two, at least 2; register 0 is hardwired to zero.
NREAD, 2, number of read ports, 1 to 4.
AW, $clog2(NREGS), address width (derived; not overridden).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
rd_addr  in  NREAD*AW  packed read addresses; port k uses bits [k*AW +: AW].
rd_data  out  NREAD*XLEN  packed read data, combinational.
rd_ready  out  NREAD  port k data is final (no pending write).
alloc_valid  in  1  request to mark a destination pending.
alloc_addr  in  AW  destination being allocated.
alloc_ok  out  1  combinational; allocation accepted this cycle.
wb_valid  in  1  write-back strobe.
wb_addr  in  AW  write-back destination.
wb_data  in  XLEN  write-back data.
flush  in  1  synchronous; clear all busy bits (pipeline squash).
busy_count  out  $clog2(NREGS+1)  registered count of busy bits set.
wb_err  out  1  sticky; write-back to a register that was not busy.

Behaviour:
- Reset (reset=0, asynchronous): all registers = 0, all busy = 0, busy_count = 0, wb_err = 0. Held in reset: no writes and no allocations; alloc_ok = 0.
- Register 0: reads always 0 with ready = 1. Writes are dropped. Allocation returns alloc_ok = 1 and sets no busy bit. Write-back to register 0 never sets wb_err.
- Write: when wb_valid=1 and wb_addr != 0, registers[wb_addr] <= wb_data on the clock edge, and busy[wb_addr] <= 0.
- Write to a non-busy register: data is still written; wb_err <= 1. wb_err is sticky until reset.
- Allocate: alloc_ok = alloc_valid & ~flush & (alloc_addr == 0 | ~busy[alloc_addr] | (wb_valid & wb_addr == alloc_addr)). On alloc_ok with a non-zero address, busy[alloc_addr] <= 1.
- Simultaneous write-back and allocation to the same address: data is written, and busy ends at 1 (allocation wins over the clear).
- Allocation to an address that is busy with no matching write-back: alloc_ok = 0 and no state change. This is a WAW stall, and the requester retries.
- Flush: all busy bits <= 0. Any allocation in the same cycle is rejected. A write-back in the same cycle still writes data. A write-back arriving after a flush to a now-clear register sets wb_err, which is the expected squash artefact; the verifier masks it after a flush.
- Read port k: rd_data = registers[addr_k] and rd_ready = ~busy[addr_k], evaluated combinationally against current state. Latency is 0 cycles. Write-back data becomes visible on the cycle after the write edge.
- busy_count: registered popcount of the next busy vector. It is updated on the same edge as busy and stays in the range 0 to NREGS-1.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: each read port whose address equals wb_addr (non-zero) while wb_valid=1 returns wb_data with rd_ready = 1 in the same cycle, even if the register is busy.
- Undefined: no bypass. The read returns the stored value with rd_ready = ~busy, so the consumer waits one cycle.
- Scoreboard and write behaviour are identical in both builds.

Test Plan:
- Reset, then read all addresses on every port -> rd_data = 0, rd_ready = 1, busy_count = 0, wb_err = 0.
- alloc x5 -> next cycle: read x5 gives rd_ready = 0, busy_count = 1. Then wb x5 = 0xDEADBEEF -> next cycle: rd_data = 0xDEADBEEF, rd_ready = 1, busy_count = 0.
- x5 busy, alloc x5 with no write-back -> alloc_ok = 0. Same cycle wb x5 = 0x11 plus alloc x5 -> alloc_ok = 1, data = 0x11, busy[5] stays 1.
- wb x0 = 0xFFFFFFFF, and alloc x0 -> x0 reads 0, ready = 1, alloc_ok = 1, busy_count unchanged, wb_err = 0. wb x7 with x7 not busy -> wb_err = 1 and stays 1.
- alloc x1, x2, x3, then flush -> busy_count = 0, all ready = 1. Assert reset mid-operation with busy bits set -> immediate clear, regardless of clk.
- With REGFILE_BYPASS_EN: x9 busy, wb x9 = 0x1234 while port 1 reads x9 -> same cycle rd_data = 0x1234, rd_ready = 1. Without the macro -> old value and rd_ready = 0, then 0x1234 the next cycle.
